// File: rtl/mux_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mux_alu_pipe
//  Brief    : NCH-channel operand select feeding an 8-op ALU, wrapped in a
//             two-stage valid/ready pipeline with full back-pressure.
//             Stage 1 registers the selected operands and op code, stage 2
//             registers result/carry/zero.
//  Options  : define MUX_ALU_PIPE_SAT_EN to make ADD saturate to all-ones on
//             carry and SUB saturate to zero on borrow (carry still reports
//             the overflow/borrow). Undefined: ADD/SUB wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_alu_pipe #(
    parameter  int WIDTH = 4,
    parameter  int NCH   = 2,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*WIDTH-1:0]   data_in,
    input  logic [SEL_W-1:0]       sel_a,
    input  logic [SEL_W-1:0]       sel_b,
    input  logic [2:0]             op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       result,
    output logic                   carry,
    output logic                   zero
);

    localparam logic [2:0] c_op_add   = 3'b000;
    localparam logic [2:0] c_op_sub   = 3'b001;
    localparam logic [2:0] c_op_and   = 3'b010;
    localparam logic [2:0] c_op_or    = 3'b011;
    localparam logic [2:0] c_op_xor   = 3'b100;
    localparam logic [2:0] c_op_pass  = 3'b101;
    localparam logic [2:0] c_op_shl1  = 3'b110;

`ifdef MUX_ALU_PIPE_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

    // Stage 1: selected operands and op code
    logic                s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]    s1_a_q,     s1_a_d;
    logic [WIDTH-1:0]    s1_b_q,     s1_b_d;
    logic [2:0]          s1_op_q,    s1_op_d;

    // Stage 2: registered ALU outputs
    logic                s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]    result_q,   result_d;
    logic                carry_q,    carry_d;
    logic                zero_q,     zero_d;

    logic                w_s2_adv;
    logic                w_s1_adv;
    logic                w_in_accept;
    logic [WIDTH-1:0]    w_mux_a;
    logic [WIDTH-1:0]    w_mux_b;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH-1:0]    w_alu_res;
    logic                w_alu_carry;

    // Handshake: a stage advances when the stage after it can take its data
    always_comb begin
        w_s2_adv    = !s2_valid_q || out_ready;
        w_s1_adv    = s1_valid_q && w_s2_adv;
        in_ready    = !s1_valid_q || w_s2_adv;
        w_in_accept = in_valid && in_ready;
    end

    // Operand select; indices at or beyond NCH read as zero
    always_comb begin
        w_mux_a = '0;
        w_mux_b = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_a == SEL_W'(k)) w_mux_a = data_in[k*WIDTH +: WIDTH];
            if (sel_b == SEL_W'(k)) w_mux_b = data_in[k*WIDTH +: WIDTH];
        end
    end

    // Stage 1 next state: load on accept, empty when drained into stage 2
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (w_in_accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = w_mux_a;
            s1_b_d     = w_mux_b;
            s1_op_d    = op;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // ALU on the stage-1 registers; carry taken from a WIDTH+1 bit sum/difference
    always_comb begin
        w_sum       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        w_diff      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (s1_op_q)
            c_op_add: begin
                w_alu_carry = w_sum[WIDTH];
                w_alu_res   = (c_sat_en && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
            end
            c_op_sub: begin
                w_alu_carry = w_diff[WIDTH];
                w_alu_res   = (c_sat_en && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
            end
            c_op_and:  w_alu_res = s1_a_q & s1_b_q;
            c_op_or:   w_alu_res = s1_a_q | s1_b_q;
            c_op_xor:  w_alu_res = s1_a_q ^ s1_b_q;
            c_op_pass: w_alu_res = s1_a_q;
            c_op_shl1: begin
                w_alu_res   = {s1_a_q[WIDTH-2:0], 1'b0};
                w_alu_carry = s1_a_q[WIDTH-1];
            end
            default: begin
                // SHR1, logical
                w_alu_res   = {1'b0, s1_a_q[WIDTH-1:1]};
                w_alu_carry = s1_a_q[0];
            end
        endcase
    end

    // Stage 2 next state: outputs only change when the consumer can move on
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        if (w_s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = w_alu_res;
                carry_d  = w_alu_carry;
                zero_d   = (w_alu_res == '0);
            end
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire
